// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Sequences single CPU load/store requests onto a tri-port data memory.
// The memory has a synchronous write port, a read port with a 1-cycle
// registered read, and a tri-stated read data bus.
//
// The unit:
//   - checks request alignment,
//   - holds the address and data stable for the whole access,
//   - enables the memory read port only during the data cycle,
//   - extracts the byte/half/word from the read data and sign- or
//     zero-extends it.
//
// Configuration macro: MISALIGN_TRAP_EN
//   defined   : misaligned requests are rejected. The memory is not touched,
//               and the request completes one cycle after accept with
//               misaligned_out=1.
//   undefined : misaligned_out is tied low. The latched address is aligned
//               down (word clears [1:0], half clears [0]), and the access is
//               performed normally.
//
// Parameters
//   ADDRESS_WIDTH : byte-address width shared with the memory
//
// Ports
//   clock_in              : single clock (memory read/write clocks tie here)
//   reset_in              : synchronous, active-high reset
//   req_in                : request valid; accepted only while ready_out=1
//   we_in                 : 1=store, 0=load
//   memMode_in            : 0x=word, 10=half, 11=byte
//   unsigned_in           : zero-extend byte/half loads
//   address_in            : byte address
//   store_data_in         : store data, right-justified
//   ready_out             : high only in IDLE
//   done_out              : 1-cycle completion pulse
//   misaligned_out        : valid with done_out; 1=request rejected
//   load_data_out         : extended load result, held until the next load
//   mem_write_out         : memory write enable
//   mem_memMode_out       : latched access mode (memory selects lanes)
//   mem_write_address_out : latched address
//   mem_read_address_out  : latched address
//   mem_write_data_out    : latched store data
//   mem_read_en_out       : memory read-port output enable
//   mem_read_data_in      : memory read data (Z when not enabled)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     req_in,
    input  logic                     we_in,
    input  logic [1:0]               memMode_in,
    input  logic                     unsigned_in,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic [31:0]              store_data_in,
    output logic                     ready_out,
    output logic                     done_out,
    output logic                     misaligned_out,
    output logic [31:0]              load_data_out,
    output logic                     mem_write_out,
    output logic [1:0]               mem_memMode_out,
    output logic [ADDRESS_WIDTH-1:0] mem_write_address_out,
    output logic [ADDRESS_WIDTH-1:0] mem_read_address_out,
    output logic [31:0]              mem_write_data_out,
    output logic                     mem_read_en_out,
    input  logic [31:0]              mem_read_data_in
);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD_ADDR,
        LOAD_DATA,
        RESP
    } state_t;

    state_t state, state_next;

    // Request registers, latched at accept.
    logic                     we_q;
    logic [1:0]               mode_q;
    logic                     unsigned_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [31:0]              data_q;
    logic                     misaligned_q;
    logic [31:0]              load_data_q;

    logic                     req_misaligned;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic                     accept;
    logic [7:0]               byte_val;
    logic [15:0]              half_val;
    logic [31:0]              extracted;

    assign accept = (state == IDLE) && req_in;

    // Alignment handling on the incoming request.
    // memMode_in[1]=0 selects a word access; 10 is half; 11 is byte.
`ifdef MISALIGN_TRAP_EN
    always_comb begin
        req_misaligned = 1'b0;
        req_address    = address_in;
        if (!memMode_in[1])
            req_misaligned = (address_in[1:0] != 2'b00);
        else if (!memMode_in[0])
            req_misaligned = address_in[0];
    end
`else
    always_comb begin
        req_misaligned = 1'b0;
        req_address    = address_in;
        if (!memMode_in[1])
            req_address[1:0] = 2'b00;
        else if (!memMode_in[0])
            req_address[0] = 1'b0;
    end
`endif

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_in) begin
                    if (req_misaligned)
                        state_next = RESP;
                    else if (we_in)
                        state_next = STORE;
                    else
                        state_next = LOAD_ADDR;
                end
            end
            STORE:     state_next = RESP;
            LOAD_ADDR: state_next = LOAD_DATA;
            LOAD_DATA: state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Lane extraction from the registered read word.
    // A shift keeps the lane select width-clean.
    always_comb begin
        byte_val  = 8'(mem_read_data_in >> {address_q[1:0], 3'b000});
        half_val  = 16'(mem_read_data_in >> {address_q[1], 4'b0000});
        extracted = mem_read_data_in;
        if (mode_q[1]) begin
            if (mode_q[0])
                extracted = {{24{~unsigned_q & byte_val[7]}}, byte_val};
            else
                extracted = {{16{~unsigned_q & half_val[15]}}, half_val};
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            mode_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            address_q    <= '0;
            data_q       <= 32'h0;
            misaligned_q <= 1'b0;
            load_data_q  <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q         <= we_in;
                mode_q       <= memMode_in;
                unsigned_q   <= unsigned_in;
                address_q    <= req_address;
                data_q       <= store_data_in;
                misaligned_q <= req_misaligned;
            end
            if (state == LOAD_DATA)
                load_data_q <= extracted;
        end
    end

    // Strobes are gated by reset so that an aborted STORE writes nothing,
    // and an aborted request never signals completion.
    assign ready_out             = (state == IDLE);
    assign done_out              = (state == RESP) && !reset_in;
    assign misaligned_out        = (state == RESP) && !reset_in && misaligned_q;
    assign load_data_out         = load_data_q;
    assign mem_write_out         = (state == STORE) && we_q && !reset_in;
    assign mem_read_en_out       = (state == LOAD_DATA) && !reset_in;
    assign mem_memMode_out       = mode_q;
    assign mem_write_address_out = address_q;
    assign mem_read_address_out  = address_q;
    assign mem_write_data_out    = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit with a behavioural tri-port memory.
// Expected completions are pushed to a scoreboard queue when a request is
// driven, and popped when done_out is seen.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          uns = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   sdata = 32'h0;
    logic          ready, done, mis, mwr, mren;
    logic [31:0]   ldata, mwdata;
    logic [1:0]    mmode;
    logic [AW-1:0] mwaddr, mraddr;
    wire  [31:0]   mrdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDRESS_WIDTH(AW)) dut (
        .clock_in(clk), .reset_in(rst), .req_in(req), .we_in(we),
        .memMode_in(mode), .unsigned_in(uns), .address_in(addr),
        .store_data_in(sdata), .ready_out(ready), .done_out(done),
        .misaligned_out(mis), .load_data_out(ldata), .mem_write_out(mwr),
        .mem_memMode_out(mmode), .mem_write_address_out(mwaddr),
        .mem_read_address_out(mraddr), .mem_write_data_out(mwdata),
        .mem_read_en_out(mren), .mem_read_data_in(mrdata)
    );

    // Tri-port memory model.
    // It has a byte-lane synchronous write, a registered word read, and a
    // tri-stated read bus.
    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [31:0] rd_q = 32'h0;

    always @(posedge clk) begin
        if (mwr) begin
            if (!mmode[1]) begin
                for (int b = 0; b < 4; b++)
                    mem[{mwaddr[AW-1:2], 2'(b)}] <= mwdata[8*b +: 8];
            end else if (!mmode[0]) begin
                mem[{mwaddr[AW-1:1], 1'b0}] <= mwdata[7:0];
                mem[{mwaddr[AW-1:1], 1'b1}] <= mwdata[15:8];
            end else begin
                mem[mwaddr] <= mwdata[7:0];
            end
        end
        rd_q <= {mem[{mraddr[AW-1:2], 2'd3}], mem[{mraddr[AW-1:2], 2'd2}],
                 mem[{mraddr[AW-1:2], 2'd1}], mem[{mraddr[AW-1:2], 2'd0}]};
    end

    assign mrdata = mren ? rd_q : 32'hzzzzzzzz;

    typedef struct {
        logic        mis;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_load = 32'h0;
    logic [31:0] word10 = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("ready_wait", 32'(ready), 32'd1);
    endtask

    // Issue one request and check its completion against the scoreboard.
    // With busy=1, a spurious store request is held while the unit is busy.
    task automatic op(input string tag, input bit w, input logic [1:0] m, input bit u,
                      input logic [AW-1:0] a, input logic [31:0] d, input bit exp_mis,
                      input logic [31:0] exp_data, input int exp_lat, input bit busy);
        exp_t e;
        int   n;
        wait_ready();
        req = 1'b1; we = w; mode = m; uns = u; addr = a; sdata = d;
        e.mis = exp_mis;
        e.lat = exp_lat;
        if (!w && !exp_mis) last_load = exp_data;
        e.data = last_load;
        sb.push_back(e);
        @(posedge clk); #1;
        req = 1'b0;
        if (busy) begin
            req = 1'b1; we = 1'b1; mode = 2'b00; addr = 8'h20; sdata = 32'hCAFEF00D;
        end
        n = 1;
        while (!done && n < 10) begin
            @(posedge clk); #1; n++;
        end
        req = 1'b0;
        e = sb.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, n, e.lat);
        check({tag, "_misaligned"}, 32'(mis), 32'(e.mis));
        check({tag, "_data"}, ldata, e.data);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        // 1. Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mis", 32'(mis), 32'd0);
        check("rst_mwr", 32'(mwr), 32'd0);
        check("rst_mren", 32'(mren), 32'd0);
        check("rst_ldata", ldata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 2. Word store/load with latency checks.
        op("sw10", 1, 2'b00, 0, 8'h10, 32'hDEADBEEF, 0, 0, 2, 0);
        op("lw10", 0, 2'b00, 0, 8'h10, 0, 0, 32'hDEADBEEF, 3, 0);

        // 3. Sub-word extraction and extension.
        op("lb13",  0, 2'b11, 0, 8'h13, 0, 0, 32'hFFFFFFDE, 3, 0);
        op("lbu13", 0, 2'b11, 1, 8'h13, 0, 0, 32'h000000DE, 3, 0);
        op("lh12",  0, 2'b10, 0, 8'h12, 0, 0, 32'hFFFFDEAD, 3, 0);
        op("lhu10", 0, 2'b10, 1, 8'h10, 0, 0, 32'h0000BEEF, 3, 0);

        // 4. Sub-word stores.
        op("sb11",   1, 2'b11, 0, 8'h11, 32'h000000AA, 0, 0, 2, 0);
        op("lw10_b", 0, 2'b00, 0, 8'h10, 0, 0, 32'hDEADAAEF, 3, 0);
        op("sh12",   1, 2'b10, 0, 8'h12, 32'h00001234, 0, 0, 2, 0);
        op("lw10_h", 0, 2'b00, 0, 8'h10, 0, 0, 32'h1234AAEF, 3, 0);
        op("sb14",   1, 2'b11, 0, 8'h14, 32'h0000007F, 0, 0, 2, 0);
        op("lb14",   0, 2'b11, 0, 8'h14, 0, 0, 32'h0000007F, 3, 0);

        // 5. Misaligned handling.
`ifdef MISALIGN_TRAP_EN
        op("sw12_mis", 1, 2'b00, 0, 8'h12, 32'h11111111, 1, 0, 1, 0);
        op("lh13_mis", 0, 2'b10, 0, 8'h13, 0, 1, 0, 1, 0);
        word10 = 32'h1234AAEF;
`else
        op("sw12_aln", 1, 2'b00, 0, 8'h12, 32'h11111111, 0, 0, 2, 0);
        op("lh13_aln", 0, 2'b10, 0, 8'h13, 0, 0, 32'h00001111, 3, 0);
        word10 = 32'h11111111;
`endif
        op("lw10_m", 0, 2'b00, 0, 8'h10, 0, 0, word10, 3, 0);

        // 6a. Reset during the STORE cycle aborts the write.
        wait_ready();
        req = 1'b1; we = 1'b1; mode = 2'b00; addr = 8'h10; sdata = 32'h55555555;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_mwr", 32'(mwr), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_load = 32'h0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_ldata", ldata, 32'h0);
        @(posedge clk); #1;
        check("abort_no_done", 32'(done), 32'd0);
        op("lw10_abort", 0, 2'b00, 0, 8'h10, 0, 0, word10, 3, 0);

        // 6b. A request held while busy is ignored.
        op("lw10_busy", 0, 2'b00, 0, 8'h10, 0, 0, word10, 3, 1);
        op("lw20", 0, 2'b00, 0, 8'h20, 0, 0, 32'h0, 3, 0);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
